hdmi_mem_arbiter: RTL and testbench
===================================

Name: hdmi_mem_arbiter

Overview:
- Shares one fixed-latency read port of the HDMI sample memory between two requesters:
  - the video pixel fetcher (24-bit RGB);
  - the audio sample fetcher (16-bit PCM).
- Sits between the HDMI feeders and the memory.
- Video has fixed priority. A starvation counter guarantees audio service.
- Returned read data is routed back to the requester that issued the read, using an in-flight tag pipeline.

Parameters:
- ADDR_W, 19, memory word address width.
- RD_LAT, 2, memory read latency in cycles (issue cycle to mem_rdata valid); must be >= 1.
- STARVE_MAX, 8, maximum cycles a pending audio request may lose arbitration before it is forced through; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- vid_req  in  1  video read request; held until granted
- vid_addr  in  ADDR_W  video read address; stable while vid_req is high
- vid_gnt  out  1  video request accepted this cycle
- vid_data  out  24  returned pixel
- vid_data_valid  out  1  vid_data valid; one-cycle pulse
- aud_req  in  1  audio read request; held until granted
- aud_addr  in  ADDR_W  audio read address
- aud_gnt  out  1  audio request accepted this cycle
- aud_data  out  16  returned sample (mem_rdata[15:0])
- aud_data_valid  out  1  aud_data valid; one-cycle pulse
- mem_rdy  in  1  memory can accept a read this cycle
- mem_req  out  1  read issue strobe
- mem_addr  out  ADDR_W  read address
- mem_rdata  in  24  read data, valid RD_LAT cycles after the issue cycle

Behaviour:
- Reset values:
  - All outputs 0.
  - Starvation counter 0.
  - Tag pipeline cleared.
  - FSM in VID_PRI.
- Grants are combinational in the cycle of the request:
  - A transfer happens when req & gnt.
  - mem_req = vid_gnt | aud_gnt.
  - mem_addr = address of the granted requester, or 0 when there is no grant.
- mem_rdy = 0:
  - No grants.
  - Starvation counter holds its value.
  - In-flight reads still retire.
- FSM, two states:
  - VID_PRI:
    - vid_req wins when both requesters are pending.
    - Each cycle with aud_req & !aud_gnt & mem_rdy increments the starvation counter.
    - When the counter reaches STARVE_MAX, go to AUD_PRI.
  - AUD_PRI:
    - aud_req wins.
    - On aud_gnt: clear the counter and return to VID_PRI.
    - If aud_req drops without a grant: clear the counter and return to VID_PRI. Audio is not expected to withdraw.
- Any aud_gnt clears the starvation counter. Counter width is clog2(STARVE_MAX+1) and it saturates at STARVE_MAX.
- At most one grant per cycle; vid_gnt and aud_gnt are never both 1.
- Tag pipeline:
  - RD_LAT stages of {valid, is_audio}, shifted every cycle regardless of mem_rdy.
  - When the tag at stage RD_LAT shows a valid read, register mem_rdata into vid_data or aud_data on the next edge.
  - Assert the matching data_valid for one cycle.
- Latency: grant in cycle N leads to data_valid high in cycle N+RD_LAT+1. vid_data_valid and aud_data_valid are never both high.
- Data registers hold their last value when not valid.
- Back-to-back issue is allowed every cycle; throughput is 1 read per cycle.
- Reset mid-operation:
  - All in-flight tags are discarded.
  - No data_valid pulse occurs after reset deassertion until a new grant.

Optional Feature:
- Macro: HDMI_MEM_ARB_STATS_EN.
- Defined, adds outputs:
  - vid_grant_cnt (32): wrapping count of video grants.
  - aud_grant_cnt (32): wrapping count of audio grants.
  - aud_force_cnt (16): saturating count of AUD_PRI entries.
  - All three reset to 0.
- Undefined: these ports and counters are absent. Arbitration and timing are identical in both builds.

Decomposition:
- Package hdmi_pkg holds:
  - arb_state_t enum {VID_PRI, AUD_PRI};
  - tag struct {valid, is_audio};
  - RGB_W = 24;
  - PCM_W = 16.
- One sub-module, hdmi_tag_pipe: parameterized RD_LAT shift register of tags with asynchronous clear.

Test Plan:
- Video only, vid_req held 4 cycles at addresses 0x10..0x13, mem_rdy = 1, RD_LAT = 2 -> vid_gnt every cycle; vid_data_valid in cycles 3..6 with the matching mem_rdata; aud_data_valid stays 0.
- Both requesters held continuously, STARVE_MAX = 8 -> 8 video grants, then 1 audio grant, repeating; aud_force_cnt increments per forced grant when stats are enabled.
- mem_rdy = 0 for 5 cycles with both requesters pending, counter at 3 -> no grants; counter stays 3; issued reads still return at N+RD_LAT+1.
- Alternating video and audio grants, RD_LAT = 3 -> each data word appears on the correct output exactly 4 cycles after its grant; the two valid pulses never overlap.
- Reset asserted 1 cycle after a grant -> outputs 0 immediately; no data_valid pulse after reset release.
- Audio only, aud_addr = 0x7FFFE, mem_rdata = 0xABCDEF -> aud_data = 0xCDEF at N+RD_LAT+1.

Source files
------------

// File: rtl/hdmi_mem_arbiter_pkg.sv
// Shared types and widths for the HDMI sample-memory read arbiter.
package hdmi_pkg;

    localparam int RGB_W = 24;
    localparam int PCM_W = 16;

    typedef enum logic {
        VID_PRI = 1'b0,
        AUD_PRI = 1'b1
    } arb_state_t;

    // One in-flight read: whether a read was issued, and who issued it.
    typedef struct packed {
        logic valid;
        logic is_audio;
    } tag_t;

endpackage

// File: rtl/hdmi_mem_arbiter_if.sv
// Requester and memory-side signals of the HDMI memory arbiter.
// slave is the arbiter's view, master is the view of the feeders plus memory.
import hdmi_pkg::*;

interface hdmi_mem_arbiter_if #(
    parameter int ADDR_W = 19
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic [RGB_W-1:0]  vid_data;
    logic              vid_data_valid;
    logic              aud_req;
    logic [ADDR_W-1:0] aud_addr;
    logic              aud_gnt;
    logic [PCM_W-1:0]  aud_data;
    logic              aud_data_valid;
    logic              mem_rdy;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [RGB_W-1:0]  mem_rdata;

    modport slave (
        input  vid_req, vid_addr, aud_req, aud_addr, mem_rdy, mem_rdata,
        output vid_gnt, vid_data, vid_data_valid,
        output aud_gnt, aud_data, aud_data_valid,
        output mem_req, mem_addr
    );

    modport master (
        output vid_req, vid_addr, aud_req, aud_addr, mem_rdy, mem_rdata,
        input  vid_gnt, vid_data, vid_data_valid,
        input  aud_gnt, aud_data, aud_data_valid,
        input  mem_req, mem_addr
    );
endinterface

// File: rtl/hdmi_mem_arbiter_tag_pipe.sv
// RD_LAT-deep shift register of read tags; stage RD_LAT lines up with mem_rdata.
import hdmi_pkg::*;

module hdmi_tag_pipe #(
    parameter int RD_LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);
    tag_t stage [RD_LAT];

    // Shift every cycle; memory latency is fixed and independent of mem_rdy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
        end
    end

    assign tag_out = stage[RD_LAT-1];
endmodule

// File: rtl/hdmi_mem_arbiter.sv
// Video/audio read arbiter for the HDMI sample memory.
// Video has fixed priority; a starvation counter forces audio through after
// STARVE_MAX lost cycles. Optional statistics under HDMI_MEM_ARB_STATS_EN.
import hdmi_pkg::*;

module hdmi_mem_arbiter #(
    parameter int ADDR_W     = 19,
    parameter int RD_LAT     = 2,
    parameter int STARVE_MAX = 8
) (
    input  logic clk,
    input  logic rst,
    hdmi_mem_arbiter_if.slave bus
`ifdef HDMI_MEM_ARB_STATS_EN
    ,
    output logic [31:0] vid_grant_cnt,
    output logic [31:0] aud_grant_cnt,
    output logic [15:0] aud_force_cnt
`endif
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t        state;
    logic [CNT_W-1:0]  starve_cnt;
    logic              vid_gnt;
    logic              aud_gnt;
    logic              force_entry;
    logic [ADDR_W-1:0] addr_sel;
    tag_t              tag_in;
    tag_t              tag_out;

    // Grant decision for the current cycle; nothing is granted while in reset.
    always_comb begin
        vid_gnt     = 1'b0;
        aud_gnt     = 1'b0;
        force_entry = 1'b0;
        if (!rst && bus.mem_rdy) begin
            if (state == AUD_PRI) begin
                aud_gnt = bus.aud_req;
                vid_gnt = bus.vid_req & ~bus.aud_req;
            end else begin
                vid_gnt = bus.vid_req;
                aud_gnt = bus.aud_req & ~bus.vid_req;
            end
        end
        if (state == VID_PRI && bus.aud_req && !aud_gnt && bus.mem_rdy && !rst)
            force_entry = ({1'b0, starve_cnt} + 1'b1) >= {1'b0, STARVE_LIM};
    end

    // Address mux; a non-granted cycle presents zero.
    always_comb begin
        addr_sel = '0;
        if (vid_gnt)      addr_sel = bus.vid_addr;
        else if (aud_gnt) addr_sel = bus.aud_addr;
    end

    assign bus.vid_gnt  = vid_gnt;
    assign bus.aud_gnt  = aud_gnt;
    assign bus.mem_req  = vid_gnt | aud_gnt;
    assign bus.mem_addr = addr_sel;

    // Priority FSM and saturating starvation counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= VID_PRI;
            starve_cnt <= '0;
        end else begin
            case (state)
                VID_PRI: begin
                    if (aud_gnt) begin
                        starve_cnt <= '0;
                    end else if (force_entry) begin
                        starve_cnt <= STARVE_LIM;
                        state      <= AUD_PRI;
                    end else if (bus.aud_req && bus.mem_rdy) begin
                        starve_cnt <= starve_cnt + 1'b1;
                    end
                end
                AUD_PRI: begin
                    // A withdrawn audio request also drops the forced priority.
                    if (aud_gnt || !bus.aud_req) begin
                        starve_cnt <= '0;
                        state      <= VID_PRI;
                    end
                end
                default: begin
                    state      <= VID_PRI;
                    starve_cnt <= '0;
                end
            endcase
        end
    end

    assign tag_in = '{valid: vid_gnt | aud_gnt, is_audio: aud_gnt};

    hdmi_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Capture returning data into the owner's register; hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.vid_data       <= '0;
            bus.aud_data       <= '0;
            bus.vid_data_valid <= 1'b0;
            bus.aud_data_valid <= 1'b0;
        end else begin
            bus.vid_data_valid <= tag_out.valid & ~tag_out.is_audio;
            bus.aud_data_valid <= tag_out.valid &  tag_out.is_audio;
            if (tag_out.valid && !tag_out.is_audio) bus.vid_data <= bus.mem_rdata;
            if (tag_out.valid &&  tag_out.is_audio) bus.aud_data <= bus.mem_rdata[PCM_W-1:0];
        end
    end

`ifdef HDMI_MEM_ARB_STATS_EN
    // Grant statistics; force count saturates, grant counts wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vid_grant_cnt <= '0;
            aud_grant_cnt <= '0;
            aud_force_cnt <= '0;
        end else begin
            if (vid_gnt) vid_grant_cnt <= vid_grant_cnt + 32'd1;
            if (aud_gnt) aud_grant_cnt <= aud_grant_cnt + 32'd1;
            if (force_entry && aud_force_cnt != 16'hFFFF)
                aud_force_cnt <= aud_force_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hdmi_mem_arbiter.sv
// Directed bench for hdmi_mem_arbiter: one instance at RD_LAT=2, one at RD_LAT=3.
import hdmi_pkg::*;

module tb_hdmi_mem_arbiter;
    localparam int AW = 19;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    hdmi_mem_arbiter_if #(.ADDR_W(AW)) bus  ();
    hdmi_mem_arbiter_if #(.ADDR_W(AW)) bus3 ();

`ifdef HDMI_MEM_ARB_STATS_EN
    logic [31:0] vgc, agc, vgc3, agc3;
    logic [15:0] afc, afc3;
`endif

    hdmi_mem_arbiter #(.ADDR_W(AW), .RD_LAT(2), .STARVE_MAX(8)) dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
`ifdef HDMI_MEM_ARB_STATS_EN
        , .vid_grant_cnt (vgc), .aud_grant_cnt (agc), .aud_force_cnt (afc)
`endif
    );

    hdmi_mem_arbiter #(.ADDR_W(AW), .RD_LAT(3), .STARVE_MAX(8)) dut3 (
        .clk (clk), .rst (rst), .bus (bus3.slave)
`ifdef HDMI_MEM_ARB_STATS_EN
        , .vid_grant_cnt (vgc3), .aud_grant_cnt (agc3), .aud_force_cnt (afc3)
`endif
    );

    // Memory content: address mixed with a constant so 0x7FFFE reads 0xABCDEF.
    function automatic logic [23:0] data_of(input logic [AW-1:0] a);
        return {5'b0, a} ^ 24'hAC3211;
    endfunction

    // Fixed-latency memory models: address issued in cycle N read back in N+RD_LAT.
    logic [AW-1:0] hist2 [2];
    logic [AW-1:0] hist3 [3];
    always @(posedge clk) begin
        hist2[0] <= bus.mem_addr;
        hist2[1] <= hist2[0];
        hist3[0] <= bus3.mem_addr;
        hist3[1] <= hist3[0];
        hist3[2] <= hist3[1];
    end
    assign bus.mem_rdata  = data_of(hist2[1]);
    assign bus3.mem_rdata = data_of(hist3[2]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.vid_req  = 0; bus.vid_addr  = '0; bus.aud_req  = 0; bus.aud_addr  = '0; bus.mem_rdy  = 1;
        bus3.vid_req = 0; bus3.vid_addr = '0; bus3.aud_req = 0; bus3.aud_addr = '0; bus3.mem_rdy = 1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        if ({bus.vid_gnt, bus.aud_gnt, bus.mem_req, bus.vid_data_valid, bus.aud_data_valid} !== 5'b0) begin
            n_fail++; $display("FAIL reset.strobes got=%b exp=00000",
                {bus.vid_gnt, bus.aud_gnt, bus.mem_req, bus.vid_data_valid, bus.aud_data_valid});
        end
        n_tests++;
        if ({bus.mem_addr, bus.vid_data, bus.aud_data} !== '0) begin
            n_fail++; $display("FAIL reset.data got=%h exp=0", {bus.mem_addr, bus.vid_data, bus.aud_data});
        end
        n_tests++;
        rst = 0;
        tick();
    endtask

    task automatic test_video_only();
        for (int c = 0; c < 9; c++) begin
            bus.vid_req  = (c < 4);
            bus.vid_addr = (c < 4) ? AW'(16'h10 + c) : '0;
            @(negedge clk);
            if (bus.vid_gnt !== (c < 4) || bus.mem_req !== (c < 4)) begin
                n_fail++; $display("FAIL vid_only.gnt c=%0d got=%b%b exp=%b", c, bus.vid_gnt, bus.mem_req, (c < 4));
            end
            n_tests++;
            if (c < 4) begin
                if (bus.mem_addr !== AW'(16'h10 + c)) begin
                    n_fail++; $display("FAIL vid_only.addr c=%0d got=%h exp=%h", c, bus.mem_addr, 16'h10 + c);
                end
                n_tests++;
            end
            if (bus.vid_data_valid !== (c >= 3 && c <= 6) || bus.aud_data_valid !== 1'b0) begin
                n_fail++; $display("FAIL vid_only.valid c=%0d got=%b%b exp=%b0", c,
                    bus.vid_data_valid, bus.aud_data_valid, (c >= 3 && c <= 6));
            end
            n_tests++;
            if (c >= 3 && c <= 6) begin
                if (bus.vid_data !== data_of(AW'(16'h10 + c - 3))) begin
                    n_fail++; $display("FAIL vid_only.data c=%0d got=%h exp=%h", c, bus.vid_data, data_of(AW'(16'h10 + c - 3)));
                end
                n_tests++;
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        for (int c = 0; c < 27; c++) begin
            bus.vid_req = 1; bus.vid_addr = AW'(16'h40);
            bus.aud_req = 1; bus.aud_addr = AW'(16'h80);
            @(negedge clk);
            if (bus.vid_gnt !== (c % 9 != 8) || bus.aud_gnt !== (c % 9 == 8)) begin
                n_fail++; $display("FAIL starve.gnt c=%0d got=v%b a%b exp_aud=%b", c, bus.vid_gnt, bus.aud_gnt, (c % 9 == 8));
            end
            n_tests++;
            tick();
        end
        idle_inputs();
`ifdef HDMI_MEM_ARB_STATS_EN
        if (afc !== 16'd3 || agc !== 32'd3 || vgc !== 32'd28) begin
            n_fail++; $display("FAIL starve.stats got=f%0d a%0d v%0d exp=f3 a3 v28", afc, agc, vgc);
        end
        n_tests++;
`endif
        for (int c = 0; c < 5; c++) tick();
    endtask

    task automatic test_mem_stall();
        logic [23:0] ad;
        ad = data_of(AW'(16'h456));
        for (int c = 0; c < 18; c++) begin
            bus.vid_req  = (c <= 13); bus.vid_addr = AW'(16'h123);
            bus.aud_req  = (c <= 13); bus.aud_addr = AW'(16'h456);
            bus.mem_rdy  = !(c >= 3 && c <= 7);
            @(negedge clk);
            if (bus.vid_gnt !== ((c < 3) || (c >= 8 && c <= 12)) || bus.aud_gnt !== (c == 13)) begin
                n_fail++; $display("FAIL stall.gnt c=%0d got=v%b a%b", c, bus.vid_gnt, bus.aud_gnt);
            end
            n_tests++;
            if (bus.vid_data_valid !== ((c >= 3 && c <= 5) || (c >= 11 && c <= 15)) ||
                bus.aud_data_valid !== (c == 16)) begin
                n_fail++; $display("FAIL stall.valid c=%0d got=v%b a%b", c, bus.vid_data_valid, bus.aud_data_valid);
            end
            n_tests++;
            if (c == 4 && bus.vid_data !== data_of(AW'(16'h123))) begin
                n_fail++; $display("FAIL stall.vdata got=%h exp=%h", bus.vid_data, data_of(AW'(16'h123)));
            end
            if (c == 4) n_tests++;
            if (c == 16 && bus.aud_data !== ad[15:0]) begin
                n_fail++; $display("FAIL stall.adata got=%h exp=%h", bus.aud_data, ad[15:0]);
            end
            if (c == 16) n_tests++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_alternate_lat3();
        logic [23:0] ad;
        for (int c = 0; c < 12; c++) begin
            bus3.vid_req  = (c < 6) && (c % 2 == 0); bus3.vid_addr = AW'(16'h200 + c);
            bus3.aud_req  = (c < 6) && (c % 2 == 1); bus3.aud_addr = AW'(16'h300 + c);
            @(negedge clk);
            if (bus3.vid_gnt !== ((c < 6) && (c % 2 == 0)) || bus3.aud_gnt !== ((c < 6) && (c % 2 == 1))) begin
                n_fail++; $display("FAIL alt.gnt c=%0d got=v%b a%b", c, bus3.vid_gnt, bus3.aud_gnt);
            end
            n_tests++;
            if (bus3.vid_data_valid !== (c >= 4 && c <= 8 && c % 2 == 0) ||
                bus3.aud_data_valid !== (c >= 5 && c <= 9 && c % 2 == 1)) begin
                n_fail++; $display("FAIL alt.valid c=%0d got=v%b a%b", c, bus3.vid_data_valid, bus3.aud_data_valid);
            end
            n_tests++;
            if (bus3.vid_data_valid && bus3.aud_data_valid) begin
                n_fail++; $display("FAIL alt.overlap c=%0d got=11 exp=not both", c);
            end
            n_tests++;
            if (c >= 4 && c <= 8 && c % 2 == 0) begin
                if (bus3.vid_data !== data_of(AW'(16'h200 + c - 4))) begin
                    n_fail++; $display("FAIL alt.vdata c=%0d got=%h exp=%h", c, bus3.vid_data, data_of(AW'(16'h200 + c - 4)));
                end
                n_tests++;
            end
            if (c >= 5 && c <= 9 && c % 2 == 1) begin
                ad = data_of(AW'(16'h300 + c - 4));
                if (bus3.aud_data !== ad[15:0]) begin
                    n_fail++; $display("FAIL alt.adata c=%0d got=%h exp=%h", c, bus3.aud_data, ad[15:0]);
                end
                n_tests++;
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_audio_only();
        for (int c = 0; c < 6; c++) begin
            bus.aud_req  = (c == 0);
            bus.aud_addr = (c == 0) ? 19'h7FFFE : '0;
            @(negedge clk);
            if (bus.aud_gnt !== (c == 0) || bus.vid_gnt !== 1'b0) begin
                n_fail++; $display("FAIL aud_only.gnt c=%0d got=a%b v%b", c, bus.aud_gnt, bus.vid_gnt);
            end
            n_tests++;
            if (c == 0 && bus.mem_addr !== 19'h7FFFE) begin
                n_fail++; $display("FAIL aud_only.addr got=%h exp=7fffe", bus.mem_addr);
            end
            if (c == 0) n_tests++;
            if (bus.aud_data_valid !== (c == 3)) begin
                n_fail++; $display("FAIL aud_only.valid c=%0d got=%b exp=%b", c, bus.aud_data_valid, (c == 3));
            end
            n_tests++;
            if (c >= 3 && bus.aud_data !== 16'hCDEF) begin
                n_fail++; $display("FAIL aud_only.data c=%0d got=%h exp=cdef", c, bus.aud_data);
            end
            if (c >= 3) n_tests++;
            if (c == 5 && bus.vid_data !== data_of(AW'(16'h123))) begin
                n_fail++; $display("FAIL aud_only.vhold got=%h exp=%h", bus.vid_data, data_of(AW'(16'h123)));
            end
            if (c == 5) n_tests++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        bus.vid_req = 1; bus.vid_addr = AW'(16'h55);
        @(negedge clk);
        if (bus.vid_gnt !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid.gnt got=%b exp=1", bus.vid_gnt);
        end
        n_tests++;
        tick();
        rst = 1;
        #1;
        if ({bus.vid_gnt, bus.mem_req, bus.vid_data_valid, bus.aud_data_valid} !== 4'b0 ||
            {bus.mem_addr, bus.vid_data, bus.aud_data} !== '0) begin
            n_fail++; $display("FAIL rst_mid.outputs got=%b %h exp=0 0",
                {bus.vid_gnt, bus.mem_req, bus.vid_data_valid, bus.aud_data_valid},
                {bus.mem_addr, bus.vid_data, bus.aud_data});
        end
        n_tests++;
        tick(); tick();
        rst = 0;
        idle_inputs();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.vid_data_valid !== 1'b0 || bus.aud_data_valid !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid.valid c=%0d got=v%b a%b exp=00", c, bus.vid_data_valid, bus.aud_data_valid);
            end
            n_tests++;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_video_only();
        test_starvation();
        test_mem_stall();
        test_alternate_lat3();
        test_audio_only();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
